// File: rtl/mock8080_pkg.sv
// Shared widths and loader state encoding for the mock8080 memory slice.
package mock8080_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/ram_sp256.sv
// Single-port synchronous RAM with registered, read-before-write output.
// Read data register holds when re_i is low; array contents are never reset.
module ram_sp256
    import mock8080_pkg::*;
#(
    parameter int AW = mock8080_pkg::ADDR_W,
    parameter int DW = mock8080_pkg::DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the array yields the pre-write value on a same-address write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/module_ram.sv
// CPU program/data RAM with a byte-stream loader that holds the CPU off the bus while filling.
// Read latency 1 clk_qzt; loader accepts one byte per cycle in LOAD, abort beats a same-cycle byte.
module module_ram
    import mock8080_pkg::*;
#(
    parameter int ADDR_W = mock8080_pkg::ADDR_W,
    parameter int DATA_W = mock8080_pkg::DATA_W
) (
    input  logic              clk_qzt,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_abort,
    output logic              ld_done,
    output logic              ld_err,
    output logic [ADDR_W:0]   ld_count
);

    localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              len_ok;
    logic              hs;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    assign len_ok = (ld_len != '0) && (ld_len <= LEN_MAX);
    assign hs     = (state_q == ST_LOAD) && ld_valid && !ld_abort;

    always_ff @(posedge clk_qzt or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ld_start && len_ok) state_d = ST_LOAD;
            ST_LOAD: begin
                if (ld_abort) begin
                    state_d = ST_IDLE;
                end else if (ld_valid && rem_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_hold  = (state_q != ST_IDLE);
        ld_ready  = (state_q == ST_LOAD);
        ld_done   = (state_q == ST_DONE);
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ram_we = cpu_we;
                ram_re = 1'b1;
            end
            ST_LOAD: begin
                ram_addr  = ptr_q;
                ram_wdata = ld_data;
                ram_we    = hs;
            end
            default: ;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (state_q == ST_IDLE && ld_start) begin
            if (len_ok) begin
                ptr_d = ld_base;
                rem_d = ld_len;
                cnt_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (hs) begin
            ptr_d = ptr_q + PTR_ONE;
            rem_d = rem_q - CNT_ONE;
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_qzt or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign ld_err   = err_q;
    assign ld_count = cnt_q;

    ram_sp256 #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk_i   (clk_qzt),
        .rst_i   (reset),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (cpu_rdata)
    );

endmodule
